// File: rtl/scr1_dmem_initiator.sv
// scr1_dmem_initiator: standalone initiator on the SCR1 dmem req/ack/resp bus.
// Takes one command at a time and runs one dmem transaction for it.
// Returns read data or an error on a valid/ready result port.
// Optional feature: define SCR1_DMEM_INIT_TIMEOUT_EN to bound the wait for dmem_resp.
// The bound is TIMEOUT_CYCLES cycles.
module scr1_dmem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_width,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    // dmem initiator port
    output logic        dmem_req,
    output logic        dmem_cmd,
    output logic [1:0]  dmem_width,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_req_ack,
    input  logic [31:0] dmem_rdata,
    input  logic [1:0]  dmem_resp,
    // result port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] rsp_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [1:0] RESP_IDLE = 2'b00;
    localparam logic [1:0] RESP_OKAY = 2'b01;

    state_t state;

    // A zero limit would make the timeout fire before any response could arrive.
    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("scr1_dmem_initiator: TIMEOUT_CYCLES must be >= 1");
    end

    // Half accesses need a 2-byte aligned address and word accesses a 4-byte aligned one.
    // Width 2'b11 is never a legal access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lsb);
        logic bad;
        bad = 1'b1;
        case (width)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lsb[0];
            2'b10:   bad = |addr_lsb;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    logic cmd_bad;
    assign cmd_bad = is_misaligned(cmd_width, cmd_addr[1:0]);

`ifdef SCR1_DMEM_INIT_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    // The counter holds the idle WAIT cycles seen so far.
    // The timeout fires on the idle cycle that would bring it to TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    // Transaction FSM; every port output is a register updated here.
    // NOTE: sequential state uses non-blocking assignments only.
    // Every register then updates from the same pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b1;
            dmem_req   <= 1'b0;
            dmem_cmd   <= 1'b0;
            dmem_width <= 2'b00;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
`ifdef SCR1_DMEM_INIT_TIMEOUT_EN
            wait_cnt   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // cmd_ready is 1 whenever the FSM is idle, so cmd_valid alone is the handshake.
                    if (cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        dmem_cmd   <= cmd_write;
                        dmem_width <= cmd_width;
                        dmem_addr  <= cmd_addr;
                        dmem_wdata <= cmd_wdata;
                        if (cmd_bad) begin
                            // Rejected locally; the responder never sees this access.
                            state     <= ST_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state    <= ST_REQ;
                            dmem_req <= 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    // The request is held with stable fields until the responder takes it.
                    if (dmem_req_ack) begin
                        state    <= ST_WAIT;
                        dmem_req <= 1'b0;
`ifdef SCR1_DMEM_INIT_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end

                ST_WAIT: begin
                    if (dmem_resp == RESP_OKAY) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= dmem_cmd ? 32'h0 : dmem_rdata;
                    end else if (dmem_resp != RESP_IDLE) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
`ifdef SCR1_DMEM_INIT_TIMEOUT_EN
                        if (wait_cnt == CNT_LAST) begin
                            state     <= ST_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            timeout_q <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
`endif
                    end
                end

                ST_DONE: begin
                    if (rsp_ready) begin
                        state      <= ST_IDLE;
                        cmd_ready  <= 1'b1;
                        rsp_valid  <= 1'b0;
                        rsp_err    <= 1'b0;
                        rsp_rdata  <= '0;
                        dmem_cmd   <= 1'b0;
                        dmem_width <= 2'b00;
                        dmem_addr  <= '0;
                        dmem_wdata <= '0;
`ifdef SCR1_DMEM_INIT_TIMEOUT_EN
                        timeout_q  <= 1'b0;
`endif
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_dmem_initiator.sv
// Scoreboard bench for scr1_dmem_initiator.
// The stimulus pushes the expected result of each command.
// A monitor pops and compares it on every result handshake.
// The monitor also checks that the dmem fields stay stable while dmem_req is high.
module tb_scr1_dmem_initiator;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_width = 2'b00;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        dmem_req;
    logic        dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_req_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [1:0]  dmem_resp = 2'b00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    scr1_dmem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_width(cmd_width), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .rsp_rdata(rsp_rdata)
    );

    typedef struct packed {
        logic        err;
        logic        timeout;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   req_cycles = 0;
    int   wait_cycles = 0;

    // expected dmem fields of the command in flight
    logic        exp_cmd = 1'b0;
    logic [1:0]  exp_width = 2'b00;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;

    // responder model controls
    int          ack_stall = 0;
    int          resp_lat = 0;
    logic [1:0]  resp_code = 2'b01;
    logic [31:0] resp_data = '0;
    bit          no_resp = 1'b0;
    bit          stray = 1'b0;
    bit          pend = 1'b0;
    int          resp_wait = 0;
    int          req_seen = 0;

    function automatic rsp_t mk_rsp(input logic e, input logic t, input logic [31:0] d);
        rsp_t r;
        r.err = e;
        r.timeout = t;
        r.rdata = d;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: checks request stability and scores each result handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dmem_req) begin
                req_cycles++;
                check("dmem_cmd", {31'b0, dmem_cmd}, {31'b0, exp_cmd});
                check("dmem_width", {30'b0, dmem_width}, {30'b0, exp_width});
                check("dmem_addr", dmem_addr, exp_addr);
                check("dmem_wdata", dmem_wdata, exp_wdata);
            end
            if (!dmem_req && !rsp_valid && !cmd_ready) wait_cycles++;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got err=%0b rdata=0x%08h, expected no result",
                             rsp_err, rsp_rdata);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.timeout});
                    check("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
    end

    // Responder model: acks after ack_stall request cycles.
    // It answers resp_lat cycles after the ack.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dmem_req_ack = 1'b0;
            dmem_resp    = 2'b00;
            dmem_rdata   = '0;
            if (!rst_n) begin
                pend = 1'b0;
                req_seen = 0;
            end else if (stray) begin
                dmem_resp  = 2'b01;
                dmem_rdata = 32'hDEAD_BEEF;
                stray = 1'b0;
            end else if (pend) begin
                if (!no_resp) begin
                    if (resp_wait == 0) begin
                        dmem_resp  = resp_code;
                        dmem_rdata = resp_data;
                        pend = 1'b0;
                    end else begin
                        resp_wait--;
                    end
                end
            end else if (dmem_req) begin
                if (req_seen == ack_stall) begin
                    dmem_req_ack = 1'b1;
                    req_seen = 0;
                    pend = 1'b1;
                    resp_wait = resp_lat;
                end else begin
                    req_seen++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and wait, bounded, for its handshake.
    task automatic issue(input logic wr, input logic [1:0] w, input logic [31:0] a,
                         input logic [31:0] d, input rsp_t exp);
        exp_cmd = wr;
        exp_width = w;
        exp_addr = a;
        exp_wdata = d;
        exp_q.push_back(exp);
        cmd_write = wr;
        cmd_width = w;
        cmd_addr = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        for (int k = 0; k < 20 && !cmd_ready; k++) tick();
        if (!cmd_ready) check("cmd_ready_timeout", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait, bounded, until every expected result has been scored.
    task automatic wait_rsp();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        if (exp_q.size() != 0) begin
            check("rsp_wait_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        #12;
        check("reset cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("reset dmem_req", {31'b0, dmem_req}, 32'd0);
        check("reset dmem_addr", dmem_addr, 32'd0);
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
        check("reset rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: word read, ack at once, okay the next cycle
        req_cycles = 0; wait_cycles = 0;
        ack_stall = 0; resp_lat = 0; resp_code = 2'b01; resp_data = 32'h0000_1234;
        issue(1'b0, 2'b10, 32'h08, 32'h0, mk_rsp(1'b0, 1'b0, 32'h0000_1234));
        wait_rsp();
        check("t1 req cycles", req_cycles, 32'd1);
        check("t1 wait cycles", wait_cycles, 32'd1);

        // 2: word write with the ack stalled three cycles
        req_cycles = 0;
        ack_stall = 3; resp_data = 32'h5555_5555;
        issue(1'b1, 2'b10, 32'h10, 32'h0000_CAFE, mk_rsp(1'b0, 1'b0, 32'h0));
        wait_rsp();
        check("t2 req cycles", req_cycles, 32'd4);
        ack_stall = 0;

        // 3: misaligned and illegal commands never reach the bus
        req_cycles = 0;
        issue(1'b0, 2'b10, 32'h0E, 32'h0, mk_rsp(1'b1, 1'b0, 32'h0));
        check("t3 rsp_valid next cycle", {31'b0, rsp_valid}, 32'd1);
        check("t3 rsp_err next cycle", {31'b0, rsp_err}, 32'd1);
        wait_rsp();
        issue(1'b0, 2'b01, 32'h05, 32'h0, mk_rsp(1'b1, 1'b0, 32'h0));
        wait_rsp();
        issue(1'b1, 2'b11, 32'h00, 32'h1, mk_rsp(1'b1, 1'b0, 32'h0));
        wait_rsp();
        check("t3 req cycles", req_cycles, 32'd0);
        resp_data = 32'h0000_BEEF;
        issue(1'b0, 2'b01, 32'h06, 32'h0, mk_rsp(1'b0, 1'b0, 32'h0000_BEEF));
        wait_rsp();
        issue(1'b1, 2'b00, 32'h03, 32'hA5, mk_rsp(1'b0, 1'b0, 32'h0));
        wait_rsp();

        // 4: error response held while the result is not taken
        resp_code = 2'b10; resp_data = 32'h7777_7777;
        rsp_ready = 1'b0;
        issue(1'b0, 2'b10, 32'h20, 32'h0, mk_rsp(1'b1, 1'b0, 32'h0));
        for (int k = 0; k < 20 && !rsp_valid; k++) tick();
        for (int k = 0; k < 5; k++) begin
            check("t4 rsp_valid held", {31'b0, rsp_valid}, 32'd1);
            check("t4 rsp_err held", {31'b0, rsp_err}, 32'd1);
            check("t4 rsp_timeout held", {31'b0, rsp_timeout}, 32'd0);
            check("t4 rsp_rdata held", rsp_rdata, 32'd0);
            check("t4 cmd_ready low", {31'b0, cmd_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        wait_rsp();
        resp_code = 2'b01;

`ifdef SCR1_DMEM_INIT_TIMEOUT_EN
        // 5: no response at all ends in a timeout after TO wait cycles
        wait_cycles = 0;
        no_resp = 1'b1;
        issue(1'b0, 2'b10, 32'h30, 32'h0, mk_rsp(1'b1, 1'b1, 32'h0));
        wait_rsp();
        check("t5 wait cycles", wait_cycles, TO);
        no_resp = 1'b0;
        pend = 1'b0;
`endif

        // a stray okay while idle is discarded
        stray = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stray rsp_valid", {31'b0, rsp_valid}, 32'd0);
            check("stray cmd_ready", {31'b0, cmd_ready}, 32'd1);
        end

        // 6: asynchronous reset in WAIT, then a normal transaction
        wait_cycles = 0;
        no_resp = 1'b1;
        issue(1'b0, 2'b10, 32'h40, 32'h0, mk_rsp(1'b0, 1'b0, 32'h0));
        for (int k = 0; k < 20 && wait_cycles == 0; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("t6 dmem_req", {31'b0, dmem_req}, 32'd0);
        check("t6 dmem_addr", dmem_addr, 32'd0);
        check("t6 dmem_width", {30'b0, dmem_width}, 32'd0);
        check("t6 rsp_valid", {31'b0, rsp_valid}, 32'd0);
        exp_q.delete();
        no_resp = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        resp_data = 32'hA5A5_A5A5;
        issue(1'b0, 2'b10, 32'h44, 32'h0, mk_rsp(1'b0, 1'b0, 32'hA5A5_A5A5));
        wait_rsp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
